// File: rtl/pbit_sweep_engine_if.sv
// Bundles the p-bit sweep engine's control, CSR memory and update signals.
// master = engine side, slave = memories / p-bit array side.
interface pbit_sweep_engine_if #(
  parameter int NUM_PBITS = 16,
  parameter int NNZ       = 464,
  parameter int W         = 8
);
  localparam int RW = $clog2(NUM_PBITS + 1);
  localparam int IW = $clog2(NUM_PBITS);
  localparam int NW = $clog2(NNZ);

  logic                 start;
  logic                 stop;
  logic [NUM_PBITS-1:0] m;

  logic [RW-1:0]        row_addr;
  logic [15:0]          row_ptr_data;
  logic signed [W-1:0]  h_data;

  logic [NW-1:0]        nz_addr;
  logic signed [W-1:0]  nz_val;
  logic [IW-1:0]        nz_col;

  logic                 upd_valid;
  logic [IW-1:0]        upd_idx;
  logic signed [W-1:0]  upd_I;

  logic                 busy;
  logic                 sweep_done;
  logic [15:0]          sweep_cnt;

  modport master (
    input  start, stop, m, row_ptr_data, h_data, nz_val, nz_col,
    output row_addr, nz_addr, upd_valid, upd_idx, upd_I, busy, sweep_done, sweep_cnt
  );

  modport slave (
    output start, stop, m, row_ptr_data, h_data, nz_val, nz_col,
    input  row_addr, nz_addr, upd_valid, upd_idx, upd_I, busy, sweep_done, sweep_cnt
  );
endinterface

// File: rtl/pbit_sweep_engine.sv
// Sequential Gibbs sweep over a CSR weight matrix: per row, MAC the active
// columns, add bias, saturate, scale by beta and strobe an update.
// Define PBIT_ANNEAL_EN to compile in beta annealing and the beta output.
module pbit_sweep_engine #(
  parameter int NUM_PBITS     = 16,
  parameter int NNZ           = 464,
  parameter int W             = 8,
  parameter int SETTLE        = 3,
  parameter int FRAC          = 3
`ifdef PBIT_ANNEAL_EN
  ,
  parameter int BETA_INIT     = 8,
  parameter int BETA_STEP     = 1,
  parameter int BETA_MAX      = 64,
  parameter int ANNEAL_PERIOD = 16
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  pbit_sweep_engine_if.master   bus
`ifdef PBIT_ANNEAL_EN
  ,
  output logic [7:0]            beta
`endif
);

  localparam int IW  = $clog2(NUM_PBITS);
  localparam int RW  = $clog2(NUM_PBITS + 1);
  localparam int NW  = $clog2(NNZ);
  localparam int AW  = W + $clog2(NUM_PBITS) + 1;
  localparam int SW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic signed [63:0] SAT_HI = (64'sd1 <<< (W - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_LO = -SAT_HI - 64'sd1;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_RPTR0  = 4'd1;
  localparam logic [3:0] ST_RPTR1  = 4'd2;
  localparam logic [3:0] ST_RCAP   = 4'd3;
  localparam logic [3:0] ST_MAC    = 4'd4;
  localparam logic [3:0] ST_DRAIN  = 4'd5;
  localparam logic [3:0] ST_SAT    = 4'd6;
  localparam logic [3:0] ST_EMIT   = 4'd7;
  localparam logic [3:0] ST_SETTLE = 4'd8;

  function automatic logic signed [W-1:0] sat_w(input logic signed [63:0] x);
    if (x > SAT_HI)
      return SAT_HI[W-1:0];
    else if (x < SAT_LO)
      return SAT_LO[W-1:0];
    else
      return x[W-1:0];
  endfunction

  logic [3:0]          state_reg, state_next;
  logic [IW-1:0]       row_reg, row_next;
  logic [15:0]         start_ptr_reg, start_ptr_next;
  logic [15:0]         end_ptr_reg, end_ptr_next;
  logic [15:0]         nz_ptr_reg, nz_ptr_next;
  logic signed [W-1:0] h_reg, h_next;
  logic                issue_reg, issue_next;
  logic signed [AW-1:0] acc_reg, acc_next;
  logic [SW-1:0]       settle_cnt_reg, settle_cnt_next;
  logic                stop_pend_reg, stop_pend_next;
  logic [IW-1:0]       upd_idx_reg, upd_idx_next;
  logic signed [W-1:0] upd_i_reg, upd_i_next;
  logic                sweep_done_reg, sweep_done_next;
  logic [15:0]         sweep_cnt_reg, sweep_cnt_next;
  logic                advance;
  logic                sweep_end;

  logic signed [W-1:0] sat_acc;
  logic signed [W-1:0] sum_w;
  logic signed [W-1:0] scaled;

  // The column hit uses the live m so each row sees earlier rows' updates.
  logic [NUM_PBITS-1:0] col_match;
  logic                 m_hit;

  generate
    for (genvar gi = 0; gi < NUM_PBITS; gi++) begin : g_col
      assign col_match[gi] = bus.m[gi] && (bus.nz_col == IW'(gi));
    end
  endgenerate

  assign m_hit = |col_match;

  assign sat_acc = sat_w(64'(acc_reg));
  assign sum_w   = sat_w(64'(sat_acc) + 64'(h_reg));

`ifdef PBIT_ANNEAL_EN
  localparam int ACW = (ANNEAL_PERIOD > 1) ? $clog2(ANNEAL_PERIOD) : 1;

  logic [7:0]          beta_reg, beta_next;
  logic [ACW-1:0]      anneal_cnt_reg, anneal_cnt_next;
  logic signed [63:0]  prod;

  assign prod   = 64'(sum_w) * $signed({56'd0, beta_reg});
  assign scaled = sat_w(prod >>> FRAC);
  assign beta   = beta_reg;

  always_comb begin
    beta_next       = beta_reg;
    anneal_cnt_next = anneal_cnt_reg;
    if (sweep_end) begin
      if (anneal_cnt_reg == ACW'(ANNEAL_PERIOD - 1)) begin
        anneal_cnt_next = '0;
        if ({24'd0, beta_reg} + 32'(BETA_STEP) >= 32'(BETA_MAX))
          beta_next = 8'(BETA_MAX);
        else
          beta_next = beta_reg + 8'(BETA_STEP);
      end else begin
        anneal_cnt_next = anneal_cnt_reg + ACW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beta_reg       <= 8'(BETA_INIT);
      anneal_cnt_reg <= '0;
    end else begin
      beta_reg       <= beta_next;
      anneal_cnt_reg <= anneal_cnt_next;
    end
  end
`else
  // Fixed beta of 1.0 leaves the saturated sum unchanged.
  assign scaled = sum_w;
`endif

  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    start_ptr_next  = start_ptr_reg;
    end_ptr_next    = end_ptr_reg;
    nz_ptr_next     = nz_ptr_reg;
    h_next          = h_reg;
    issue_next      = 1'b0;
    acc_next        = acc_reg;
    settle_cnt_next = settle_cnt_reg;
    stop_pend_next  = stop_pend_reg | bus.stop;
    upd_idx_next    = upd_idx_reg;
    upd_i_next      = upd_i_reg;
    sweep_done_next = 1'b0;
    sweep_cnt_next  = sweep_cnt_reg;
    advance         = 1'b0;
    sweep_end       = 1'b0;

    if (issue_reg && m_hit)
      acc_next = acc_reg + AW'(bus.nz_val);

    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_RPTR0;
          row_next   = '0;
        end
      end
      ST_RPTR0: state_next = ST_RPTR1;
      ST_RPTR1: begin
        start_ptr_next = bus.row_ptr_data;
        h_next         = bus.h_data;
        state_next     = ST_RCAP;
      end
      ST_RCAP: begin
        end_ptr_next = bus.row_ptr_data;
        nz_ptr_next  = start_ptr_reg;
        acc_next     = '0;
        state_next   = (bus.row_ptr_data > start_ptr_reg) ? ST_MAC : ST_SAT;
      end
      ST_MAC: begin
        issue_next  = 1'b1;
        nz_ptr_next = nz_ptr_reg + 16'd1;
        if ((nz_ptr_reg + 16'd1) == end_ptr_reg)
          state_next = ST_DRAIN;
      end
      ST_DRAIN: state_next = ST_SAT;
      ST_SAT: begin
        upd_i_next   = scaled;
        upd_idx_next = row_reg;
        state_next   = ST_EMIT;
      end
      ST_EMIT: begin
        if (SETTLE > 0) begin
          settle_cnt_next = SW'(SETTLE - 1);
          state_next      = ST_SETTLE;
        end else begin
          advance = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_reg == '0)
          advance = 1'b1;
        else
          settle_cnt_next = settle_cnt_reg - SW'(1);
      end
      default: state_next = ST_IDLE;
    endcase

    if (advance) begin
      if (row_reg != IW'(NUM_PBITS - 1)) begin
        row_next   = row_reg + IW'(1);
        state_next = ST_RPTR0;
      end else begin
        sweep_end       = 1'b1;
        sweep_done_next = 1'b1;
        sweep_cnt_next  = sweep_cnt_reg + 16'd1;
        row_next        = '0;
        state_next      = stop_pend_next ? ST_IDLE : ST_RPTR0;
      end
    end

    if (state_next == ST_IDLE)
      stop_pend_next = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      row_reg        <= '0;
      start_ptr_reg  <= '0;
      end_ptr_reg    <= '0;
      nz_ptr_reg     <= '0;
      h_reg          <= '0;
      issue_reg      <= 1'b0;
      acc_reg        <= '0;
      settle_cnt_reg <= '0;
      stop_pend_reg  <= 1'b0;
      upd_idx_reg    <= '0;
      upd_i_reg      <= '0;
      sweep_done_reg <= 1'b0;
      sweep_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      start_ptr_reg  <= start_ptr_next;
      end_ptr_reg    <= end_ptr_next;
      nz_ptr_reg     <= nz_ptr_next;
      h_reg          <= h_next;
      issue_reg      <= issue_next;
      acc_reg        <= acc_next;
      settle_cnt_reg <= settle_cnt_next;
      stop_pend_reg  <= stop_pend_next;
      upd_idx_reg    <= upd_idx_next;
      upd_i_reg      <= upd_i_next;
      sweep_done_reg <= sweep_done_next;
      sweep_cnt_reg  <= sweep_cnt_next;
    end
  end

  // Row pointer memory is read twice per row: start at i, end at i+1.
  assign bus.row_addr   = (state_reg == ST_RPTR1) ? (RW'(row_reg) + RW'(1)) : RW'(row_reg);
  assign bus.nz_addr    = nz_ptr_reg[NW-1:0];
  assign bus.upd_valid  = (state_reg == ST_EMIT);
  assign bus.upd_idx    = upd_idx_reg;
  assign bus.upd_I      = upd_i_reg;
  assign bus.busy       = (state_reg != ST_IDLE);
  assign bus.sweep_done = sweep_done_reg;
  assign bus.sweep_cnt  = sweep_cnt_reg;

endmodule

// File: doc/pbit_sweep_engine.md
PBIT_SWEEP_ENGINE -- requirements
Module: pbit_sweep_engine

Interface
REQ-001 SHALL have parameter NUM_PBITS, default 16, number of p-bits in the network.
REQ-002 SHALL have parameter NNZ, default 464, depth of the nonzero-weight memory.
REQ-003 SHALL have parameter W, default 8, signed width of weights, bias and I output.
REQ-004 SHALL have parameter SETTLE, default 3, idle cycles after each update for p-bit settling.
REQ-005 SHALL have parameter FRAC, default 3, fractional bits of beta.
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 start  in  1  begin continuous sweeps; sampled only in IDLE.
REQ-009 stop  in  1  finish the current sweep, then return to IDLE.
REQ-010 m  in  NUM_PBITS  current binary p-bit states.
REQ-011 row_addr  out  clog2(NUM_PBITS+1)  row-pointer/bias memory address; row_ptr_data, h_data valid one cycle later.
REQ-012 row_ptr_data  in  16 / h_data  in  W  CSR row pointer and signed bias.
REQ-013 nz_addr  out  clog2(NNZ)  nonzero address; nz_val (W signed), nz_col (clog2(NUM_PBITS)) valid one cycle later.
REQ-014 upd_valid  out  1, upd_idx  out  clog2(NUM_PBITS), upd_I  out  W signed  one-cycle update strobe, target p-bit, input current.
REQ-015 busy  out  1 (state != IDLE); sweep_done  out  1 (one-cycle pulse per completed sweep); sweep_cnt  out  16 (completed sweeps).

Function
REQ-016 FSM states SHALL be IDLE, RPTR0, RPTR1, RCAP, MAC, DRAIN, SAT, EMIT, SETTLE.
REQ-017 IDLE->RPTR0 on start; row index i=0 at sweep start.
REQ-018 RPTR0 drives row_addr=i; RPTR1 drives row_addr=i+1 and captures start pointer and h; RCAP captures end pointer; n=end-start.
REQ-019 RCAP->MAC if n>0, else ->SAT with accumulator 0.
REQ-020 MAC SHALL issue nz_addr=start..end-1, one per cycle, n cycles, then DRAIN; each returned entry adds nz_val to accumulator iff m[nz_col]=1.
REQ-021 Accumulator SHALL be W+clog2(NUM_PBITS)+1 bits signed; no internal overflow.
REQ-022 SAT: saturate accumulator to W bits, add sign-extended h, saturate to W bits, apply beta scaling (REQ-035/036), register to upd_I.
REQ-023 EMIT asserts upd_valid for exactly one cycle with upd_idx=i, then SETTLE for SETTLE cycles (SETTLE=0: skip).
REQ-024 Latency, start-sampling edge = edge 0: upd_valid high after edge n+5 for n>0, after edge 4 for n=0.
REQ-025 After SETTLE: if i<NUM_PBITS-1, i+=1 ->RPTR0; else pulse sweep_done, sweep_cnt+=1 (wraps 65535->0), i=0, ->IDLE if stop pending else ->RPTR0.
REQ-026 stop sampled high in any state SHALL set a pending flag cleared on entering IDLE; start and stop together in IDLE SHALL run exactly one sweep.
REQ-027 start while busy SHALL be ignored.
REQ-028 m SHALL be sampled live each MAC/DRAIN cycle (sequential Gibbs ordering).

Reset
REQ-029 On reset: state IDLE, i=0, accumulator 0, upd_valid=0, upd_idx=0, upd_I=0, busy=0, sweep_done=0, sweep_cnt=0, stop pending=0, row_addr=0, nz_addr=0, beta=BETA_INIT.
REQ-030 Reset mid-sweep SHALL abort immediately with no further upd_valid.

Configuration
REQ-031 Macro PBIT_ANNEAL_EN SHALL compile in beta annealing.
REQ-032 With it, parameters BETA_INIT (default 8), BETA_STEP (default 1), BETA_MAX (default 64), ANNEAL_PERIOD (default 16) SHALL exist.
REQ-033 With it, beta SHALL increase by BETA_STEP every ANNEAL_PERIOD completed sweeps, saturating at BETA_MAX.
REQ-034 With it, output beta  out  8 SHALL expose current beta.
REQ-035 With it, upd_I SHALL be sat_W((beta*sum) >>> FRAC), arithmetic shift.
REQ-036 Without it, beta SHALL be constant 1<<FRAC, upd_I = saturated sum, no beta port.

Verification
REQ-037 NUM_PBITS=4, row0 {+5@col1, -3@col2}, m=0110, h0=2, start -> upd_idx=0, upd_I=4, upd_valid after edge 7.
REQ-038 Row0 {100@col1, 100@col2}, m=1111, h0=10 -> upd_I=127; weights -100,-100, h0=-10 -> upd_I=-128.
REQ-039 Empty row1, h1=-7 -> upd_idx=1, upd_I=-7, upd_valid 4 cycles after RPTR0 entry for row1.
REQ-040 start with stop in same cycle -> exactly 4 upd_valid pulses, one sweep_done, sweep_cnt=1, busy=0 after.
REQ-041 Reset asserted during MAC of row2 -> outputs at REQ-029 values next cycle, no upd_valid until restart.
REQ-042 PBIT_ANNEAL_EN, BETA_INIT=8, BETA_STEP=8, ANNEAL_PERIOD=1, sum=4 -> sweep 1 upd_I=4, sweep 2 upd_I=8.
